// File: rtl/pla_pkg.sv
// Shared types for the programmable PLA evaluator: literal codes, config opcodes, FSM states.
package pla_pkg;

  typedef logic [1:0] lit_t;

  localparam lit_t LIT_DC   = 2'b11;
  localparam lit_t LIT_ONE  = 2'b10;
  localparam lit_t LIT_ZERO = 2'b01;
  localparam lit_t LIT_VOID = 2'b00;

  typedef enum logic {CFG_WRITE = 1'b0, CFG_CLEAR = 1'b1} cfg_op_e;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CFG = 2'd2, CLEAR = 2'd3} state_e;

endpackage

// File: rtl/pla_prog_eval_term.sv
// One product term: a cube of {allow1,allow0} literal pairs matched against the input vector.
module pla_term_match
  import pla_pkg::*;
#(
  parameter int N_IN = 10
) (
  input  logic [2*N_IN-1:0] cube,
  input  logic [N_IN-1:0]   x,
  output logic              hit
);

  logic [N_IN-1:0] lit_ok;

  // Each literal passes when its allow-bit for the current input value is set.
  for (genvar i = 0; i < N_IN; i++) begin : g_lit
    lit_t lit;
    assign lit       = cube[2*i +: 2];
    assign lit_ok[i] = x[i] ? lit[1] : lit[0];
  end

  assign hit = &lit_ok;

endmodule

// File: rtl/pla_prog_eval.sv
// Runtime-programmable two-stage PLA: register-held AND/OR planes, config FSM, valid/ready pipeline.
module pla_prog_eval
  import pla_pkg::*;
#(
  parameter int N_IN    = 10,
  parameter int N_OUT   = 6,
  parameter int N_TERMS = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_IN-1:0]            in_x,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_OUT-1:0]           out_z,
  output logic                       out_any,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic                       cfg_op,
  input  logic [$clog2(N_TERMS)-1:0] cfg_addr,
  input  logic [2*N_IN-1:0]          cfg_and,
  input  logic [N_OUT-1:0]           cfg_or,
  output logic                       busy
);

  localparam int AW     = $clog2(N_TERMS);
  localparam int STAGES = 2;

  state_e                             state;
  logic                               run_en;
  logic [STAGES:1]                    vld_pipe;
  logic [N_TERMS-1:0][2*N_IN-1:0]     and_plane;
  logic [N_TERMS-1:0][N_OUT-1:0]      or_plane;
  logic [N_TERMS-1:0]                 hit, hit_q;
  logic [AW-1:0]                      clr_cnt;
  logic [N_OUT-1:0]                   z_d;
  logic                               adv, accept, cfg_fire, cfg_wr;

  assign adv       = !vld_pipe[STAGES] | out_ready;
  assign in_ready  = run_en & (state == RUN) & adv & !cfg_valid;
  assign accept    = in_valid & in_ready;
  assign cfg_ready = (state == CFG);
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign cfg_wr    = cfg_fire & (cfg_op_e'(cfg_op) == CFG_WRITE);
  assign busy      = (state != RUN);
  assign out_valid = vld_pipe[STAGES];

  for (genvar t = 0; t < N_TERMS; t++) begin : g_term
    pla_term_match #(.N_IN(N_IN)) u_match (
      .cube(and_plane[t]),
      .x   (in_x),
      .hit (hit[t])
    );
  end

  always_comb begin
    z_d = '0;
    for (int k = 0; k < N_OUT; k++)
      for (int t = 0; t < N_TERMS; t++)
        z_d[k] = z_d[k] | (hit_q[t] & or_plane[t][k]);
  end

  // run_en keeps in_ready low while reset is held, since state alone reads RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      clr_cnt <= '0;
      run_en  <= 1'b0;
    end else begin
      run_en <= 1'b1;
      case (state)
        RUN:   if (cfg_valid) state <= DRAIN;
        DRAIN: if (vld_pipe == '0) state <= CFG;
        CFG: begin
          if (!cfg_valid) state <= RUN;
          else if (cfg_op_e'(cfg_op) == CFG_CLEAR) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(N_TERMS - 1)) state <= CFG;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_plane <= '0;
      or_plane  <= '0;
    end else if (cfg_wr) begin
      and_plane[cfg_addr] <= cfg_and;
      or_plane[cfg_addr]  <= cfg_or;
    end else if (state == CLEAR) begin
      and_plane[clr_cnt] <= '0;
      or_plane[clr_cnt]  <= '0;
    end
  end

  // Both stages advance together; output regs hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      hit_q    <= '0;
      out_z    <= '0;
      out_any  <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], accept};
      if (accept) hit_q <= hit;
      if (vld_pipe[1]) begin
        out_z   <= z_d;
        out_any <= |hit_q;
      end
    end
  end

endmodule
